// File: rtl/gp_mem_access_ctrl.sv
// Memory-access sequencer upstream of the general-purpose register file: runs one
// load/store/move at a time, drives the external memory handshake and the RF write-back port.
module gp_mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [1:0]        i_op_cmd,
  input  logic [ADDR_W-1:0] i_op_addr,
  input  logic [31:0]       i_op_wdata,
  input  logic [2:0]        i_op_dest,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic [2:0]        o_gp_sel_z,
  output logic [1:0]        o_gp_mem_instr,
  output logic [31:0]       o_gp_mem_data,
  output logic              o_gp_ack,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  localparam logic [1:0] CmdNop   = 2'b00;
  localparam logic [1:0] CmdLoad  = 2'b01;
  localparam logic [1:0] CmdStore = 2'b10;
  localparam logic [1:0] CmdMove  = 2'b11;

  localparam logic [1:0] GpWrite = 2'b11;
  localparam logic [1:0] GpNone  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StWb,
    StDone,
    StErr
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        r_dest, w_dest_nxt;
  logic              r_op_ready, w_op_ready_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;
  logic              r_mem_wr, w_mem_wr_nxt;
  logic [2:0]        r_gp_sel_z, w_gp_sel_z_nxt;
  logic [1:0]        r_gp_mem_instr, w_gp_mem_instr_nxt;
  logic [31:0]       r_gp_mem_data, w_gp_mem_data_nxt;
  logic              r_gp_ack, w_gp_ack_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_accept;
  logic              w_timeout;

  assign w_accept  = i_op_valid & r_op_ready;
  assign w_timeout = (r_cnt + 8'd1) == TimeoutCnt;

  // Outputs are computed one cycle ahead from the next state so every port is a flop.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_dest_nxt         = r_dest;
    w_mem_addr_nxt     = r_mem_addr;
    w_mem_wdata_nxt    = r_mem_wdata;
    w_gp_sel_z_nxt     = r_gp_sel_z;
    w_gp_mem_data_nxt  = r_gp_mem_data;
    w_mem_rd_nxt       = 1'b0;
    w_mem_wr_nxt       = 1'b0;
    w_gp_mem_instr_nxt = GpNone;
    w_gp_ack_nxt       = 1'b0;
    w_done_nxt         = 1'b0;
    w_err_nxt          = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept && (i_op_cmd != CmdNop)) begin
          w_mem_addr_nxt  = i_op_addr;
          w_mem_wdata_nxt = i_op_wdata;
          w_dest_nxt      = i_op_dest;
          w_cnt_nxt       = 8'd0;
          unique case (i_op_cmd)
            CmdLoad: begin
              w_state_nxt  = StRead;
              w_mem_rd_nxt = 1'b1;
            end
            CmdStore: begin
              w_state_nxt  = StWrite;
              w_mem_wr_nxt = 1'b1;
            end
            CmdMove: begin
              w_state_nxt        = StWb;
              w_gp_mem_instr_nxt = GpWrite;
              w_gp_sel_z_nxt     = i_op_dest;
              w_gp_mem_data_nxt  = i_op_wdata;
              w_gp_ack_nxt       = 1'b1;
            end
            default: w_state_nxt = StIdle;
          endcase
        end
      end
      StRead: begin
        if (i_mem_ack) begin
          w_state_nxt        = StWb;
          w_gp_mem_instr_nxt = GpWrite;
          w_gp_sel_z_nxt     = r_dest;
          w_gp_mem_data_nxt  = i_mem_rdata;
          w_gp_ack_nxt       = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + 8'd1;
          w_mem_rd_nxt = 1'b1;
        end
      end
      StWrite: begin
        if (i_mem_ack) begin
          w_state_nxt = StDone;
          w_done_nxt  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + 8'd1;
          w_mem_wr_nxt = 1'b1;
        end
      end
      StWb: begin
        w_state_nxt = StDone;
        w_done_nxt  = 1'b1;
      end
      StDone:  w_state_nxt = StIdle;
      StErr:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase

    w_op_ready_nxt = (w_state_nxt == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= StIdle;
      r_cnt          <= 8'd0;
      r_dest         <= 3'd0;
      r_op_ready     <= 1'b1;
      r_mem_addr     <= '0;
      r_mem_wdata    <= 32'd0;
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_gp_sel_z     <= 3'd0;
      r_gp_mem_instr <= GpNone;
      r_gp_mem_data  <= 32'd0;
      r_gp_ack       <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dest         <= w_dest_nxt;
      r_op_ready     <= w_op_ready_nxt;
      r_mem_addr     <= w_mem_addr_nxt;
      r_mem_wdata    <= w_mem_wdata_nxt;
      r_mem_rd       <= w_mem_rd_nxt;
      r_mem_wr       <= w_mem_wr_nxt;
      r_gp_sel_z     <= w_gp_sel_z_nxt;
      r_gp_mem_instr <= w_gp_mem_instr_nxt;
      r_gp_mem_data  <= w_gp_mem_data_nxt;
      r_gp_ack       <= w_gp_ack_nxt;
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign o_op_ready     = r_op_ready;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_rd       = r_mem_rd;
  assign o_mem_wr       = r_mem_wr;
  assign o_gp_sel_z     = r_gp_sel_z;
  assign o_gp_mem_instr = r_gp_mem_instr;
  assign o_gp_mem_data  = r_gp_mem_data;
  assign o_gp_ack       = r_gp_ack;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_gp_mem_access_ctrl.sv
// Self-checking bench for gp_mem_access_ctrl: a cycle-level latency model drives per-cycle
// expectations, plus literal pulse/cycle tallies per command.
module tb_gp_mem_access_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_cmd;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic [2:0]    op_dest;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [2:0]    gp_sel_z;
  logic [1:0]    gp_mem_instr;
  logic [31:0]   gp_mem_data;
  logic          gp_ack;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  gp_mem_access_ctrl #(
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_op_valid    (op_valid),
    .o_op_ready    (op_ready),
    .i_op_cmd      (op_cmd),
    .i_op_addr     (op_addr),
    .i_op_wdata    (op_wdata),
    .i_op_dest     (op_dest),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_rd      (mem_rd),
    .o_mem_wr      (mem_wr),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_gp_sel_z    (gp_sel_z),
    .o_gp_mem_instr(gp_mem_instr),
    .o_gp_mem_data (gp_mem_data),
    .o_gp_ack      (gp_ack),
    .o_done        (done),
    .o_err         (err)
  );

  typedef enum int {KIdle, KRd, KWr, KWb, KDone, KErr, KRst} kind_e;

  int n_chk  = 0;
  int n_fail = 0;

  logic          chk_en = 1'b0;
  logic          e_ready, e_rd, e_wr, e_gack, e_done, e_err, e_chk_addr, e_chk_wd;
  logic [1:0]    e_instr;
  logic [2:0]    e_sel;
  logic [31:0]   e_data, e_wdata;
  logic [AW-1:0] e_addr;

  // Last value written into the register file; sel/data hold it between write-backs.
  logic [2:0]    m_sel  = 3'd0;
  logic [31:0]   m_data = 32'd0;

  int t_rd = 0, t_wr = 0, t_wb = 0, t_done = 0, t_err = 0;
  int b_rd, b_wr, b_wb, b_done, b_err;
  logic [2:0]  s_sel  = 3'd0;
  logic [31:0] s_data = 32'd0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Which phase cycle c (counted from the accept edge) must be in, from the latency rules.
  function automatic kind_e kind_of(input logic [1:0] cmd, input int a, input int c);
    bit ok;
    int term;
    ok   = (a >= 1) && (a <= int'(TO));
    term = ok ? a : int'(TO);
    if (cmd == 2'b00) return KIdle;
    if (cmd == 2'b11) return (c == 0) ? KWb : ((c == 1) ? KDone : KIdle);
    if (c < term) return (cmd == 2'b01) ? KRd : KWr;
    if (!ok) return (c == term) ? KErr : KIdle;
    if (cmd == 2'b10) return (c == term) ? KDone : KIdle;
    if (c == term) return KWb;
    return (c == term + 1) ? KDone : KIdle;
  endfunction

  task automatic set_exp(input kind_e k, input logic [AW-1:0] addr, input logic [31:0] wd);
    e_ready    = (k == KIdle) || (k == KRst);
    e_rd       = (k == KRd);
    e_wr       = (k == KWr);
    e_instr    = (k == KWb) ? 2'b11 : 2'b00;
    e_gack     = (k == KWb);
    e_done     = (k == KDone);
    e_err      = (k == KErr);
    e_chk_addr = (k == KRd) || (k == KWr) || (k == KRst);
    e_chk_wd   = (k == KWr) || (k == KRst);
    e_addr     = (k == KRst) ? '0 : addr;
    e_wdata    = (k == KRst) ? 32'd0 : wd;
    e_sel      = m_sel;
    e_data     = m_data;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("op_ready", 32'(op_ready), 32'(e_ready));
      check("mem_rd", 32'(mem_rd), 32'(e_rd));
      check("mem_wr", 32'(mem_wr), 32'(e_wr));
      check("gp_mem_instr", 32'(gp_mem_instr), 32'(e_instr));
      check("gp_ack", 32'(gp_ack), 32'(e_gack));
      check("gp_sel_z", 32'(gp_sel_z), 32'(e_sel));
      check("gp_mem_data", gp_mem_data, e_data);
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      if (e_chk_addr) check("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_chk_wd) check("mem_wdata", mem_wdata, e_wdata);
      if (mem_rd) t_rd <= t_rd + 1;
      if (mem_wr) t_wr <= t_wr + 1;
      if (done) t_done <= t_done + 1;
      if (err) t_err <= t_err + 1;
      if (gp_ack) begin
        t_wb   <= t_wb + 1;
        s_sel  <= gp_sel_z;
        s_data <= gp_mem_data;
      end
    end
  end

  task automatic snap();
    b_rd   = t_rd;
    b_wr   = t_wr;
    b_wb   = t_wb;
    b_done = t_done;
    b_err  = t_err;
  endtask

  // a = edge (counted from accept) at which mem_ack is sampled high; 0 = never.
  task automatic run_op(input logic [1:0] cmd, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [2:0] dest, input int a,
                        input logic [31:0] rd, input bit poke);
    kind_e k;
    int    c;
    snap();
    op_valid = 1'b1;
    op_cmd   = cmd;
    op_addr  = addr;
    op_wdata = wd;
    op_dest  = dest;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      k = kind_of(cmd, a, c);
      if (k == KWb) begin
        m_sel  = dest;
        m_data = (cmd == 2'b11) ? wd : rd;
      end
      set_exp(k, addr, wd);
      mem_ack   = (a >= 1) && (c == a - 1);
      mem_rdata = mem_ack ? rd : (32'h0BAD_0000 | 32'(c));
      op_valid  = poke && (k != KIdle);
      op_cmd    = poke ? 2'b10 : cmd;
      op_addr   = poke ? 16'hFFFF : addr;
      c++;
    end while (k != KIdle);
  endtask

  initial begin
    rst       = 1'b0;
    op_valid  = 1'b1;
    op_cmd    = 2'b01;
    op_addr   = 16'h5555;
    op_wdata  = 32'hFFFF_FFFF;
    op_dest   = 3'd7;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;

    // Reset held for two edges with a command pending.
    @(posedge clk); #1;
    set_exp(KRst, '0, 32'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    set_exp(KRst, '0, 32'd0);
    rst      = 1'b1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    set_exp(KIdle, '0, 32'd0);
    @(posedge clk); #1;

    run_op(2'b01, 16'h0040, 32'd0, 3'd5, 3, 32'hDEAD_BEEF, 1'b0);
    check("load rd cycles", 32'(t_rd - b_rd), 32'd3);
    check("load wb count", 32'(t_wb - b_wb), 32'd1);
    check("load wb data", s_data, 32'hDEAD_BEEF);
    check("load wb sel", 32'(s_sel), 32'd5);
    check("load done count", 32'(t_done - b_done), 32'd1);

    run_op(2'b10, 16'h1234, 32'hA5A5_0F0F, 3'd0, 1, 32'd0, 1'b0);
    check("store wr cycles", 32'(t_wr - b_wr), 32'd1);
    check("store wb count", 32'(t_wb - b_wb), 32'd0);
    check("store done count", 32'(t_done - b_done), 32'd1);

    run_op(2'b11, 16'h0000, 32'h0000_0007, 3'd2, 0, 32'd0, 1'b0);
    check("move wb data", s_data, 32'd7);
    check("move wb sel", 32'(s_sel), 32'd2);
    check("move mem req", 32'(t_rd - b_rd + t_wr - b_wr), 32'd0);

    run_op(2'b00, 16'h0BEE, 32'h1111_1111, 3'd1, 0, 32'd0, 1'b0);
    check("nop done count", 32'(t_done - b_done), 32'd0);

    run_op(2'b01, 16'h00FF, 32'd0, 3'd3, 0, 32'd0, 1'b0);
    check("timeout rd cycles", 32'(t_rd - b_rd), 32'd15);
    check("timeout err count", 32'(t_err - b_err), 32'd1);
    check("timeout wb count", 32'(t_wb - b_wb), 32'd0);
    check("timeout done count", 32'(t_done - b_done), 32'd0);

    run_op(2'b01, 16'h0101, 32'd0, 3'd6, 15, 32'h1357_9BDF, 1'b0);
    check("late ack err count", 32'(t_err - b_err), 32'd0);
    check("late ack wb data", s_data, 32'h1357_9BDF);

    run_op(2'b01, 16'h2222, 32'd0, 3'd1, 4, 32'hCAFE_F00D, 1'b1);
    check("busy poke wr cycles", 32'(t_wr - b_wr), 32'd0);
    check("busy poke wb data", s_data, 32'hCAFE_F00D);

    run_op(2'b10, 16'h3333, 32'h5A5A_5A5A, 3'd0, 0, 32'd0, 1'b0);
    check("store timeout err", 32'(t_err - b_err), 32'd1);
    check("store timeout wr cycles", 32'(t_wr - b_wr), 32'd15);

    // Reset asserted while a load is waiting on memory.
    snap();
    op_valid = 1'b1;
    op_cmd   = 2'b01;
    op_addr  = 16'h0ABC;
    op_wdata = 32'd0;
    op_dest  = 3'd4;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      set_exp(KRd, 16'h0ABC, 32'd0);
      op_valid = 1'b0;
      mem_ack  = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    m_sel  = 3'd0;
    m_data = 32'd0;
    set_exp(KRst, '0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    set_exp(KIdle, '0, 32'd0);
    @(posedge clk); #1;
    check("reset mid-read wb count", 32'(t_wb - b_wb), 32'd0);
    check("reset mid-read rd cycles", 32'(t_rd - b_rd), 32'd3);

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gp_mem_access_ctrl.md
Name: gp_mem_access_ctrl

Overview:
- Memory-access sequencer sitting directly upstream of the general-purpose register file.
- Accepts one load/store/move command at a time from the instruction decoder and runs the external memory read or write handshake.
- On loads and moves, drives the register file's write-back port: select Z, 2-bit mem instruction, 32-bit data and data-ack, for exactly one cycle.
- Reports done or timeout error back to control.

Parameters:
ADDR_W, 16, width of memory address
TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous, active-low reset
op_valid  in  1  command present
op_ready  out  1  block idle, command accepted when op_valid & op_ready
op_cmd  in  2  00 NOP, 01 load, 10 store, 11 register move
op_addr  in  ADDR_W  memory address
op_wdata  in  32  store data or move data, normally register-file B output
op_dest  in  3  destination register for load/move
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  store data
mem_rd  out  1  read request, level
mem_wr  out  1  write request, level
mem_ack  in  1  memory completes current request
mem_rdata  in  32  read data, valid with mem_ack
gp_sel_z  out  3  register-file write select
gp_mem_instr  out  2  register-file command, 11 = write, else 00
gp_mem_data  out  32  register-file write data
gp_ack  out  1  data-ack toward register file
done  out  1  one-cycle completion pulse
err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: reset rst, synchronous, active-low; clock clk. While rst=0, next edge forces the following:
  - state IDLE, op_ready=1
  - mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0
  - gp_sel_z=0, gp_mem_instr=00, gp_mem_data=0, gp_ack=0
  - done=err=0, timeout counter=0
- Reset mid-operation drops any request immediately (next edge). No write-back occurs.
- All outputs are registered (Moore, from state/latched regs).
- States: IDLE, READ, WRITE, WB, DONE, ERR.
- IDLE (op_ready=1):
  - On accept, latch addr/wdata/dest, clear counter.
  - cmd 01 -> READ; 10 -> WRITE; 11 -> WB with data=op_wdata.
  - cmd 00 is consumed with no effect and no done pulse; block stays IDLE.
- READ: mem_rd=1, mem_addr=latched addr.
  - mem_ack=1 at an edge: capture mem_rdata -> WB.
  - Else counter+1; counter reaching TIMEOUT -> ERR.
- WRITE: mem_wr=1, mem_addr/mem_wdata=latched. mem_ack -> DONE; timeout rule as READ.
- ack and timeout on the same edge: ack wins.
- mem_rd and mem_wr are never high together; both are low outside READ/WRITE.
- WB, exactly one cycle:
  - gp_mem_instr=11, gp_sel_z=dest, gp_mem_data=data, gp_ack=1.
  - All four return to 00/hold/hold/0 after that cycle.
  - -> DONE.
- DONE: done=1 one cycle -> IDLE.
- ERR: err=1 one cycle, no write-back, no done -> IDLE.
- op_ready=0 in every state except IDLE; op_valid is ignored while busy.
- Latency, with accept at edge E0 and mem_ack sampled at E1:
  - load: write-back cycle E1-E2, done E2-E3, op_ready high from E3.
  - store: done E1-E2.
  - move: write-back E0-E1, done E1-E2.
- gp_sel_z and gp_mem_data hold their last value when idle. Only gp_mem_instr/gp_ack qualify them.

Test Plan:
- Reset: drive rst=0 for 2 edges with op_valid=1 -> every output at reset value, no mem_rd/mem_wr; release -> op_ready=1.
- Load: op_cmd=01, addr=0x0040, dest=5; memory acks after 3 cycles with 0xDEADBEEF -> mem_rd high 3 cycles, then one cycle gp_mem_instr=11, gp_sel_z=5, gp_mem_data=0xDEADBEEF, gp_ack=1, then done pulse.
- Store: op_cmd=10, addr=0x1234, wdata=0xA5A5_0F0F; ack on the first cycle -> mem_wr one cycle with those values, done next cycle, gp_mem_instr stays 00.
- Move: op_cmd=11, wdata=0x0000_0007, dest=2 -> write-back cycle right after accept with data 7 to sel 2, then done; mem_rd/mem_wr stay 0.
- Timeout: load with TIMEOUT=15, mem_ack never asserted -> mem_rd high 15 cycles, err one cycle, no gp_ack, op_ready back.
  - Repeat with ack on the 15th cycle -> normal write-back, no err.
- Busy/reset: a second op_valid during READ is ignored. rst=0 asserted during READ -> mem_rd low the next cycle, no write-back, op_ready=1 after release.
